// File: rtl/micro_bundle_packer.sv
// micro_bundle_packer
//   Producer side of the fetch -> decode-queue micro-op interface. Micro-ops
//   arrive one per cycle over a valid/ready handshake. They are packed into
//   MICRO_Q_N-slot bundles. Occupied slots are contiguous from slot 0, and
//   empty slots carry MICRO_NOP. A bundle closes when it is full, or on the
//   last micro-op of an x86 instruction. A closed bundle moves into the
//   output register, which drives the fet_* arrays and fet_inst_valid.
//
// Ports
//   clk, rstn         clock, asynchronous active-low reset
//   in_valid/in_ready handshake for one micro-op per cycle
//   in_* fields       micro-op fields; in_last marks the end of an x86 instruction
//   fet_* arrays      bundle slots (unpacked, MICRO_Q_N entries each)
//   fet_inst_valid    bundle valid
//   stall             decode queue is not consuming; the output is held
//   flush             drops the partial bundle and the presented bundle

module micro_bundle_packer #(
  parameter int                  MICRO_Q_N  = 4,
  parameter int                  MICRO_W    = 8,
  parameter logic [MICRO_W-1:0]  MICRO_NOP  = '0,
  parameter int                  REG_ADDR_W = 5,
  parameter int                  IMM_W      = 64,
  parameter int                  DISP_W     = 32,
  parameter int                  BIT_MODE_W = 2,
  parameter int                  ADDR_W     = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MICRO_W-1:0]    in_opcode,
  input  logic [REG_ADDR_W-1:0] in_reg_addr_d,
  input  logic [REG_ADDR_W-1:0] in_reg_addr_s,
  input  logic [REG_ADDR_W-1:0] in_reg_addr_t,
  input  logic [IMM_W-1:0]      in_immediate,
  input  logic [DISP_W-1:0]     in_displacement,
  input  logic [BIT_MODE_W-1:0] in_bit_mode,
  input  logic [ADDR_W-1:0]     in_pc,
  input  logic                  in_last,
  output logic [MICRO_W-1:0]    fet_opcode       [MICRO_Q_N],
  output logic [REG_ADDR_W-1:0] fet_reg_addr_d   [MICRO_Q_N],
  output logic [REG_ADDR_W-1:0] fet_reg_addr_s   [MICRO_Q_N],
  output logic [REG_ADDR_W-1:0] fet_reg_addr_t   [MICRO_Q_N],
  output logic [IMM_W-1:0]      fet_immediate    [MICRO_Q_N],
  output logic [DISP_W-1:0]     fet_displacement [MICRO_Q_N],
  output logic [BIT_MODE_W-1:0] fet_bit_mode     [MICRO_Q_N],
  output logic [ADDR_W-1:0]     fet_pc           [MICRO_Q_N],
  output logic                  fet_inst_valid,
  input  logic                  stall,
  input  logic                  flush
);

  localparam int IDX_W = $clog2(MICRO_Q_N);
  localparam int CNT_W = IDX_W + 1;

  // Fill buffer
  logic [MICRO_W-1:0]    r_fill_opcode [MICRO_Q_N];
  logic [REG_ADDR_W-1:0] r_fill_rd     [MICRO_Q_N];
  logic [REG_ADDR_W-1:0] r_fill_rs     [MICRO_Q_N];
  logic [REG_ADDR_W-1:0] r_fill_rt     [MICRO_Q_N];
  logic [IMM_W-1:0]      r_fill_imm    [MICRO_Q_N];
  logic [DISP_W-1:0]     r_fill_disp   [MICRO_Q_N];
  logic [BIT_MODE_W-1:0] r_fill_mode   [MICRO_Q_N];
  logic [ADDR_W-1:0]     r_fill_pc     [MICRO_Q_N];
  logic [CNT_W-1:0]      r_fill_cnt;
  logic                  r_fill_closed;

  // Output register
  logic [MICRO_W-1:0]    r_out_opcode [MICRO_Q_N];
  logic [REG_ADDR_W-1:0] r_out_rd     [MICRO_Q_N];
  logic [REG_ADDR_W-1:0] r_out_rs     [MICRO_Q_N];
  logic [REG_ADDR_W-1:0] r_out_rt     [MICRO_Q_N];
  logic [IMM_W-1:0]      r_out_imm    [MICRO_Q_N];
  logic [DISP_W-1:0]     r_out_disp   [MICRO_Q_N];
  logic [BIT_MODE_W-1:0] r_out_mode   [MICRO_Q_N];
  logic [ADDR_W-1:0]     r_out_pc     [MICRO_Q_N];
  logic                  r_out_valid;

  logic             w_accept;
  logic             w_take;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_close;
  logic             w_consume;
  logic             w_transfer;
  logic [IDX_W-1:0] w_slot;

  assign in_ready = ~r_fill_closed & ~flush;

  // Handshake, slot allocation and bundle movement decisions
  always_comb begin
    w_accept   = in_valid & in_ready;
    // A NOP carries no work, so it is accepted but never occupies a slot.
    w_take     = w_accept & (in_opcode != MICRO_NOP);
    w_cnt_nxt  = r_fill_cnt + {{(CNT_W-1){1'b0}}, w_take};
    w_close    = w_accept & ((w_cnt_nxt == CNT_W'(MICRO_Q_N)) |
                             (in_last & (w_cnt_nxt != {CNT_W{1'b0}})));
    w_consume  = r_out_valid & ~stall & ~flush;
    w_transfer = r_fill_closed & (~r_out_valid | w_consume) & ~flush;
    w_slot     = r_fill_cnt[IDX_W-1:0];
  end

  // Fill buffer: collect accepted micro-ops until the bundle closes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fill_cnt    <= '0;
      r_fill_closed <= 1'b0;
      for (int i = 0; i < MICRO_Q_N; i++) begin
        r_fill_opcode[i] <= MICRO_NOP;
        r_fill_rd[i]     <= '0;
        r_fill_rs[i]     <= '0;
        r_fill_rt[i]     <= '0;
        r_fill_imm[i]    <= '0;
        r_fill_disp[i]   <= '0;
        r_fill_mode[i]   <= '0;
        r_fill_pc[i]     <= '0;
      end
    end else if (flush || w_transfer) begin
      r_fill_cnt    <= '0;
      r_fill_closed <= 1'b0;
    end else if (w_accept) begin
      // Slot index is in range: accept only happens while the buffer is open,
      // and an open buffer always has fill_cnt < MICRO_Q_N.
      if (w_take) begin
        r_fill_opcode[w_slot] <= in_opcode;
        r_fill_rd[w_slot]     <= in_reg_addr_d;
        r_fill_rs[w_slot]     <= in_reg_addr_s;
        r_fill_rt[w_slot]     <= in_reg_addr_t;
        r_fill_imm[w_slot]    <= in_immediate;
        r_fill_disp[w_slot]   <= in_displacement;
        r_fill_mode[w_slot]   <= in_bit_mode;
        r_fill_pc[w_slot]     <= in_pc;
      end else begin
        r_fill_cnt <= r_fill_cnt;
      end
      r_fill_cnt    <= w_cnt_nxt;
      r_fill_closed <= w_close;
    end else begin
      r_fill_cnt    <= r_fill_cnt;
      r_fill_closed <= r_fill_closed;
    end
  end

  // Output register: load closed bundles and hold them through stall
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      for (int i = 0; i < MICRO_Q_N; i++) begin
        r_out_opcode[i] <= MICRO_NOP;
        r_out_rd[i]     <= '0;
        r_out_rs[i]     <= '0;
        r_out_rt[i]     <= '0;
        r_out_imm[i]    <= '0;
        r_out_disp[i]   <= '0;
        r_out_mode[i]   <= '0;
        r_out_pc[i]     <= '0;
      end
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_transfer) begin
      r_out_valid <= 1'b1;
      for (int i = 0; i < MICRO_Q_N; i++) begin
        // Slots past the fill count hold stale data from earlier bundles.
        if (CNT_W'(i) < r_fill_cnt) begin
          r_out_opcode[i] <= r_fill_opcode[i];
        end else begin
          r_out_opcode[i] <= MICRO_NOP;
        end
        r_out_rd[i]   <= r_fill_rd[i];
        r_out_rs[i]   <= r_fill_rs[i];
        r_out_rt[i]   <= r_fill_rt[i];
        r_out_imm[i]  <= r_fill_imm[i];
        r_out_disp[i] <= r_fill_disp[i];
        r_out_mode[i] <= r_fill_mode[i];
        r_out_pc[i]   <= r_fill_pc[i];
      end
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign fet_inst_valid   = r_out_valid;
  assign fet_opcode       = r_out_opcode;
  assign fet_reg_addr_d   = r_out_rd;
  assign fet_reg_addr_s   = r_out_rs;
  assign fet_reg_addr_t   = r_out_rt;
  assign fet_immediate    = r_out_imm;
  assign fet_displacement = r_out_disp;
  assign fet_bit_mode     = r_out_mode;
  assign fet_pc           = r_out_pc;

  micro_bundle_packer_chk #(
    .MICRO_Q_N (MICRO_Q_N),
    .MICRO_W   (MICRO_W),
    .MICRO_NOP (MICRO_NOP)
  ) u_chk (
    .clk    (clk),
    .rstn   (rstn),
    .valid  (r_out_valid),
    .opcode (r_out_opcode)
  );

endmodule

// micro_bundle_packer_chk
//   Bundle shape invariant. A valid bundle starts with a real micro-op, and
//   its non-NOP slots are contiguous from slot 0.
// Ports: clk, rstn, valid (bundle valid), opcode (bundle opcode slots)
module micro_bundle_packer_chk #(
  parameter int                 MICRO_Q_N = 4,
  parameter int                 MICRO_W   = 8,
  parameter logic [MICRO_W-1:0] MICRO_NOP = '0
) (
  input logic               clk,
  input logic               rstn,
  input logic               valid,
  input logic [MICRO_W-1:0] opcode [MICRO_Q_N]
);

  // Check the presented bundle shape on every clock edge
  always @(posedge clk) begin
    if (rstn && valid) begin
      assert (opcode[0] != MICRO_NOP);
      for (int i = 1; i < MICRO_Q_N; i++) begin
        assert (!((opcode[i] != MICRO_NOP) && (opcode[i-1] == MICRO_NOP)));
      end
    end
  end

endmodule

// File: tb/tb_micro_bundle_packer.sv
module tb_micro_bundle_packer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_opcode;
  logic [4:0]  in_reg_addr_d, in_reg_addr_s, in_reg_addr_t;
  logic [63:0] in_immediate;
  logic [31:0] in_displacement;
  logic [1:0]  in_bit_mode;
  logic [63:0] in_pc;
  logic        in_last;
  logic [7:0]  fet_opcode       [4];
  logic [4:0]  fet_reg_addr_d   [4];
  logic [4:0]  fet_reg_addr_s   [4];
  logic [4:0]  fet_reg_addr_t   [4];
  logic [63:0] fet_immediate    [4];
  logic [31:0] fet_displacement [4];
  logic [1:0]  fet_bit_mode     [4];
  logic [63:0] fet_pc           [4];
  logic        fet_inst_valid;
  logic        stall;
  logic        flush;

  micro_bundle_packer dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_reg_addr_d(in_reg_addr_d),
    .in_reg_addr_s(in_reg_addr_s), .in_reg_addr_t(in_reg_addr_t),
    .in_immediate(in_immediate), .in_displacement(in_displacement),
    .in_bit_mode(in_bit_mode), .in_pc(in_pc), .in_last(in_last),
    .fet_opcode(fet_opcode), .fet_reg_addr_d(fet_reg_addr_d),
    .fet_reg_addr_s(fet_reg_addr_s), .fet_reg_addr_t(fet_reg_addr_t),
    .fet_immediate(fet_immediate), .fet_displacement(fet_displacement),
    .fet_bit_mode(fet_bit_mode), .fet_pc(fet_pc),
    .fet_inst_valid(fet_inst_valid), .stall(stall), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [7:0]  op;
    logic        last;
    logic        stall;
    logic        flush;
    logic        rdy;   // expected in_ready during the cycle
    logic        val;   // expected fet_inst_valid after the edge
    logic [31:0] ops;   // expected {slot3,slot2,slot1,slot0} opcodes when val
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic v, logic [7:0] op, logic last, logic st,
                              logic fl, logic rdy, logic val, logic [31:0] ops);
    vec_t r;
    r.v = v; r.op = op; r.last = last; r.stall = st; r.flush = fl;
    r.rdy = rdy; r.val = val; r.ops = ops;
    return r;
  endfunction

  function automatic logic [31:0] pack_ops();
    return {fet_opcode[3], fet_opcode[2], fet_opcode[1], fet_opcode[0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every field is derived from the opcode so payload routing can be checked.
  task automatic drive(input logic v, input logic [7:0] op, input logic last,
                       input logic st, input logic fl);
    in_valid        = v;
    in_opcode       = op;
    in_last         = last;
    stall           = st;
    flush           = fl;
    in_reg_addr_d   = op[4:0];
    in_reg_addr_s   = op[4:0] ^ 5'h1f;
    in_reg_addr_t   = op[4:0] ^ 5'h0a;
    in_immediate    = {8{op}};
    in_displacement = {4{op}};
    in_bit_mode     = op[1:0];
    in_pc           = {56'h0, op};
  endtask

  task automatic run_row(input vec_t r, input int idx);
    logic [31:0] e;
    logic        ok;
    @(negedge clk);
    drive(r.v, r.op, r.last, r.stall, r.flush);
    #1;
    check($sformatf("ready[%0d]", idx), {63'h0, in_ready}, {63'h0, r.rdy});
    @(posedge clk);
    #1;
    check($sformatf("valid[%0d]", idx), {63'h0, fet_inst_valid}, {63'h0, r.val});
    if (r.val) begin
      check($sformatf("ops[%0d]", idx), {32'h0, pack_ops()}, {32'h0, r.ops});
      e  = r.ops;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (e[8*i +: 8] != 8'h00) begin
          if (fet_pc[i] !== {56'h0, e[8*i +: 8]}) ok = 1'b0;
          if (fet_immediate[i] !== {8{e[8*i +: 8]}}) ok = 1'b0;
          if (fet_reg_addr_s[i] !== (e[8*i+:5] ^ 5'h1f)) ok = 1'b0;
        end
      end
      check($sformatf("fields[%0d]", idx), {63'h0, ok}, 64'h1);
    end
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #12;
    check("rst_valid", {63'h0, fet_inst_valid}, 64'h0);
    check("rst_ops", {32'h0, pack_ops()}, 64'h0);
    check("rst_pc3", fet_pc[3], 64'h0);
    check("rst_ready", {63'h0, in_ready}, 64'h1);
    @(negedge clk);
    rstn = 1'b1;

    //               v     op    last  stall flush rdy   val   ops
    // three ops, last on C
    tbl.push_back(mk(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 8'h13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00131211));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    // six ops spanning two bundles
    tbl.push_back(mk(1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 8'h23, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 8'h24, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 8'h25, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h24232221));
    tbl.push_back(mk(1'b1, 8'h25, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 8'h26, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00002625));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    // NOP then X(last); then NOP(last) alone
    tbl.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 8'h31, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000031));
    tbl.push_back(mk(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    // stall for five cycles while a second bundle closes
    tbl.push_back(mk(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 8'h42, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 8'h43, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00004241));
    tbl.push_back(mk(1'b1, 8'h43, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00004241));
    tbl.push_back(mk(1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00004241));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00004241));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00004241));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00004443));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    // flush with two ops buffered and a bundle valid
    tbl.push_back(mk(1'b1, 8'h51, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 8'h52, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000051));
    tbl.push_back(mk(1'b1, 8'h52, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000051));
    tbl.push_back(mk(1'b1, 8'h53, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000051));
    tbl.push_back(mk(1'b1, 8'h54, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000055));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));

    foreach (tbl[k]) run_row(tbl[k], k);

    // Asynchronous reset while a bundle is valid and one op sits in the buffer
    run_row(mk(1'b1, 8'h61, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0), 100);
    run_row(mk(1'b1, 8'h62, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000061), 101);
    run_row(mk(1'b1, 8'h62, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000061), 102);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_valid", {63'h0, fet_inst_valid}, 64'h0);
    check("arst_ops", {32'h0, pack_ops()}, 64'h0);
    check("arst_pc0", fet_pc[0], 64'h0);
    check("arst_imm0", fet_immediate[0], 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    run_row(mk(1'b1, 8'h71, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0), 103);
    run_row(mk(1'b1, 8'h72, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0), 104);
    run_row(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00007271), 105);
    run_row(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0), 106);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
